// File: rtl/or_bus_master.sv
// Sequencer between an operand stream and the 1-bit OR dut bus: it polls the
// status registers, writes A and B, polls Y, reads Y back and returns it on
// the result stream. A poll that does not succeed in time aborts the pair.
module or_bus_master #(
   parameter int unsigned MAX_POLL = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             op_valid,
   input  logic             op_a,
   input  logic             op_b,
   output logic             op_ready,
   output logic             res_valid,
   output logic             res_y,
   output logic             res_err,
   input  logic             res_ready,
   output logic [2:0]       write_address,
   output logic             write_data,
   output logic             write_en,
   input  logic             write_rdy,
   output logic [2:0]       read_address,
   output logic             read_en,
   input  logic             read_data,
   input  logic             read_rdy,
   output logic [CNT_W-1:0] txn_count
);

   localparam int unsigned PW = (MAX_POLL > 2) ? $clog2(MAX_POLL) : 1;
   localparam logic [PW-1:0] POLL_LIM = PW'(MAX_POLL - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_POLL_A = 3'd1;
   localparam logic [2:0] S_WR_A   = 3'd2;
   localparam logic [2:0] S_POLL_B = 3'd3;
   localparam logic [2:0] S_WR_B   = 3'd4;
   localparam logic [2:0] S_POLL_Y = 3'd5;
   localparam logic [2:0] S_RD_Y   = 3'd6;
   localparam logic [2:0] S_OUT    = 3'd7;

   localparam logic [2:0] ADDR_A_NF  = 3'd0;
   localparam logic [2:0] ADDR_B_NF  = 3'd1;
   localparam logic [2:0] ADDR_Y_NE  = 3'd2;
   localparam logic [2:0] ADDR_Y_DAT = 3'd3;
   localparam logic [2:0] ADDR_A_WR  = 3'd4;
   localparam logic [2:0] ADDR_B_WR  = 3'd5;

   logic [2:0]       state, state_d;
   logic [PW-1:0]    poll_cnt, poll_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             res_valid_d, res_y_d, res_err_d;
   logic [CNT_W-1:0] cnt_d;
   logic             op_ready_d;
   logic [2:0]       wr_addr_d, rd_addr_d;
   logic             wr_data_d;
   logic             in_poll, poll_ok;

   // Bus enables follow the current state and the dut's ready directly
   assign in_poll  = (state == S_POLL_A) || (state == S_POLL_B) || (state == S_POLL_Y);
   assign read_en  = (in_poll || (state == S_RD_Y)) && read_rdy;
   assign write_en = ((state == S_WR_A) || (state == S_WR_B)) && write_rdy;
   assign poll_ok  = in_poll && read_en && read_data;

   // State register and registered outputs
   always_ff @(posedge CLK or posedge RST_N) begin
      if (RST_N) begin
         state         <= S_IDLE;
         poll_cnt      <= '0;
         a_q           <= 1'b0;
         b_q           <= 1'b0;
         op_ready      <= 1'b1;
         res_valid     <= 1'b0;
         res_y         <= 1'b0;
         res_err       <= 1'b0;
         write_address <= 3'd0;
         write_data    <= 1'b0;
         read_address  <= 3'd0;
         txn_count     <= '0;
      end else begin
         state         <= state_d;
         poll_cnt      <= poll_d;
         a_q           <= a_d;
         b_q           <= b_d;
         op_ready      <= op_ready_d;
         res_valid     <= res_valid_d;
         res_y         <= res_y_d;
         res_err       <= res_err_d;
         write_address <= wr_addr_d;
         write_data    <= wr_data_d;
         read_address  <= rd_addr_d;
         txn_count     <= cnt_d;
      end
   end

   // Next state, poll timeout and next values of the registered outputs
   always_comb begin
      state_d     = state;
      poll_d      = poll_cnt;
      a_d         = a_q;
      b_d         = b_q;
      res_valid_d = res_valid;
      res_y_d     = res_y;
      res_err_d   = res_err;
      cnt_d       = txn_count;
      op_ready_d  = 1'b0;
      wr_addr_d   = 3'd0;
      wr_data_d   = 1'b0;
      rd_addr_d   = 3'd0;

      case (state)
         S_IDLE: begin
            if (op_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               poll_d  = '0;
               state_d = S_POLL_A;
            end
         end
         S_POLL_A, S_POLL_B, S_POLL_Y: begin
            // A success on the limit cycle still wins over the abort
            if (poll_ok) begin
               if (state == S_POLL_A)      state_d = S_WR_A;
               else if (state == S_POLL_B) state_d = S_WR_B;
               else                        state_d = S_RD_Y;
            end else if (poll_cnt == POLL_LIM) begin
               res_valid_d = 1'b1;
               res_err_d   = 1'b1;
               res_y_d     = 1'b0;
               state_d     = S_OUT;
            end else begin
               poll_d = poll_cnt + PW'(1);
            end
         end
         S_WR_A: begin
            if (write_en) begin
               poll_d  = '0;
               state_d = S_POLL_B;
            end
         end
         S_WR_B: begin
            if (write_en) begin
               poll_d  = '0;
               state_d = S_POLL_Y;
            end
         end
         S_RD_Y: begin
            if (read_en) begin
               res_valid_d = 1'b1;
               res_err_d   = 1'b0;
               res_y_d     = read_data;
               state_d     = S_OUT;
            end
         end
         S_OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               cnt_d       = txn_count + CNT_W'(1);
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Bus address/data registers present the values for the state being entered
      case (state_d)
         S_IDLE:   op_ready_d = 1'b1;
         S_POLL_A: rd_addr_d  = ADDR_A_NF;
         S_POLL_B: rd_addr_d  = ADDR_B_NF;
         S_POLL_Y: rd_addr_d  = ADDR_Y_NE;
         S_RD_Y:   rd_addr_d  = ADDR_Y_DAT;
         S_WR_A: begin
            wr_addr_d = ADDR_A_WR;
            wr_data_d = a_d;
         end
         S_WR_B: begin
            wr_addr_d = ADDR_B_WR;
            wr_data_d = b_d;
         end
         default: op_ready_d = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_or_bus_master.sv
// Bench for or_bus_master: a behavioural OR dut on the bus side, a pair-level
// scoreboard checked every cycle, directed scenarios and a randomized run.
module tb_or_bus_master;

   logic       CLK;
   logic       RST_N;
   logic       op_valid, op_a, op_b, op_ready;
   logic       res_valid, res_y, res_err, res_ready;
   logic [2:0] write_address, read_address;
   logic       write_data, write_en, write_rdy;
   logic       read_en, read_data, read_rdy;
   logic [7:0] txn_count;

   or_bus_master #(.MAX_POLL(16), .CNT_W(8)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
      .res_valid(res_valid), .res_y(res_y), .res_err(res_err), .res_ready(res_ready),
      .write_address(write_address), .write_data(write_data), .write_en(write_en),
      .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
      .read_data(read_data), .read_rdy(read_rdy), .txn_count(txn_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Expected bus address order for one pair
   int seq[6] = '{0, 4, 1, 5, 2, 3};

   // Scoreboard state
   bit outstanding = 0;
   bit exp_a = 0, exp_b = 0, exp_err = 0;
   int phase = 0;
   int model_cnt = 0;
   bit prev_hold = 0, prev_y = 0, prev_err = 0;
   bit last_y = 0, last_err = 0;
   int trace[$];

   // Behavioural dut state and knobs
   bit dq_a[$], dq_b[$], dq_y[$];
   bit rand_mode = 0, stuck_y = 0, hold_rd_low = 0;
   int streak = 0;
   bit w_fire = 0, r_fire = 0, w_dat = 0;
   logic [2:0] w_addr = 3'd0, r_addr = 3'd0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Behavioural OR dut: FIFOs for A/B, Y formed when both hold an entry
   initial begin : dut_model
      bit ya, yb, ok, force_ok;
      read_rdy  = 1'b0;
      write_rdy = 1'b0;
      read_data = 1'b0;
      forever begin
         @(posedge CLK);
         if (RST_N) begin
            dq_a.delete(); dq_b.delete(); dq_y.delete();
         end else begin
            if (w_fire) begin
               if (w_addr == 3'd4) dq_a.push_back(w_dat);
               else if (w_addr == 3'd5) dq_b.push_back(w_dat);
            end
            if (r_fire && r_addr == 3'd3 && dq_y.size() > 0) void'(dq_y.pop_front());
            if (dq_a.size() > 0 && dq_b.size() > 0) begin
               ya = dq_a.pop_front();
               yb = dq_b.pop_front();
               dq_y.push_back(ya | yb);
            end
         end
         w_fire = 0;
         r_fire = 0;
         #1;
         force_ok  = rand_mode && (streak >= 6);
         read_rdy  = hold_rd_low ? 1'b0 : (!rand_mode || force_ok || ($urandom_range(0, 3) != 0));
         write_rdy = !rand_mode || force_ok || ($urandom_range(0, 3) != 0);
         ok        = !rand_mode || force_ok || ($urandom_range(0, 2) != 0);
         case (read_address)
            3'd0:    read_data = ok && (dq_a.size() < 2);
            3'd1:    read_data = ok && (dq_b.size() < 2);
            3'd2:    read_data = ok && !stuck_y && (dq_y.size() > 0);
            3'd3:    read_data = (dq_y.size() > 0) ? dq_y[0] : 1'b0;
            default: read_data = 1'b0;
         endcase
      end
   end

   // Per-cycle compare against the pair-level model
   initial begin : monitor
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            outstanding = 0; model_cnt = 0; phase = 0; prev_hold = 0; streak = 0;
         end
         chk("wr_en_without_rdy", int'(write_en & ~write_rdy), 0);
         chk("rd_en_without_rdy", int'(read_en & ~read_rdy), 0);
         chk("both_enables", int'(write_en & read_en), 0);
         chk("op_ready", int'(op_ready), int'(!outstanding));
         chk("txn_count", int'(txn_count), model_cnt % 256);
         if (!outstanding) chk("res_valid_idle", int'(res_valid), 0);
         if (prev_hold) begin
            chk("res_valid_hold", int'(res_valid), 1);
            chk("res_y_hold", int'(res_y), int'(prev_y));
            chk("res_err_hold", int'(res_err), int'(prev_err));
         end
         if (!RST_N) begin
            if (write_en) begin
               w_fire = 1; w_addr = write_address; w_dat = write_data;
               trace.push_back(int'(write_address));
               streak = 0;
               chk("bus_op_in_txn", int'(outstanding && phase < 6), 1);
               if (phase < 6) begin
                  chk("wr_addr", int'(write_address), seq[phase]);
                  chk("wr_data", int'(write_data), (phase == 1) ? int'(exp_a) : int'(exp_b));
               end
               phase++;
            end else if (read_en) begin
               r_fire = 1; r_addr = read_address;
               trace.push_back(int'(read_address));
               chk("bus_op_in_txn", int'(outstanding && phase < 6), 1);
               if (phase < 6) chk("rd_addr", int'(read_address), seq[phase]);
               if (read_data || read_address == 3'd3) begin
                  phase++;
                  streak = 0;
               end else begin
                  streak++;
               end
            end else begin
               streak++;
            end
            if (res_valid && res_ready) begin
               chk("res_err", int'(res_err), int'(exp_err));
               chk("res_y", int'(res_y), exp_err ? 0 : int'(exp_a | exp_b));
               if (!exp_err) chk("bus_phases_done", phase, 6);
               last_y = res_y; last_err = res_err;
               outstanding = 0;
               model_cnt++;
            end
            if (op_valid && op_ready) begin
               outstanding = 1; exp_a = op_a; exp_b = op_b; phase = 0;
            end
         end
         prev_hold = !RST_N && res_valid && !res_ready;
         prev_y    = res_y;
         prev_err  = res_err;
      end
   end

   task automatic tick;
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset;
      RST_N = 1'b1;
      tick; tick;
      RST_N = 1'b0;
   endtask

   // Offer a pair and return just after the accepting edge
   task automatic send_pair(input bit a, input bit b);
      int k = 0;
      op_a = a; op_b = b; op_valid = 1'b1;
      while (!op_ready && k < 500) begin tick; k++; end
      chk("accept_wait", int'(op_ready), 1);
      tick;
      op_valid = 1'b0;
   endtask

   task automatic take_result(input int stall);
      int k = 0;
      res_ready = 1'b0;
      while (!res_valid && k < 500) begin tick; k++; end
      chk("result_wait", int'(res_valid), 1);
      if (res_valid) begin
         repeat (stall) tick;
         res_ready = 1'b1;
         tick;
         res_ready = 1'b0;
      end
   endtask

   initial begin : global_guard
      #3000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n, k;
      bit pa[4] = '{0, 0, 1, 1};
      bit pb[4] = '{0, 1, 0, 1};
      bit py[4] = '{0, 1, 1, 1};
      RST_N = 1'b1; op_valid = 1'b1; op_a = 1'b1; op_b = 1'b1; res_ready = 1'b0;

      // Reset held with an operand offered
      repeat (3) tick;
      chk("rst_op_ready", int'(op_ready), 1);
      chk("rst_read_en", int'(read_en), 0);
      chk("rst_write_en", int'(write_en), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_txn_count", int'(txn_count), 0);
      RST_N = 1'b0;
      tick;
      chk("accept_after_release", int'(op_ready), 0);
      op_valid = 1'b0;
      take_result(0);
      chk("t1_y", int'(last_y), 1);

      // Four truth-table pairs with an always-ready dut
      do_reset;
      trace.delete();
      for (int i = 0; i < 4; i++) begin
         send_pair(pa[i], pb[i]);
         n = 1;
         while (!res_valid && n < 50) begin tick; n++; end
         chk("latency", n, 7);
         take_result(0);
         chk("t2_y", int'(last_y), int'(py[i]));
         chk("t2_err", int'(last_err), 0);
      end
      chk("t2_txn_count", int'(txn_count), 4);
      chk("t2_trace_len", trace.size(), 24);
      for (int i = 0; i < trace.size() && i < 24; i++) chk("t2_trace", trace[i], seq[i % 6]);

      // Read ready withheld for 5 cycles in POLL_A
      hold_rd_low = 1;
      tick;
      send_pair(0, 1);
      for (int i = 0; i < 5; i++) begin
         chk("t3_read_en_low", int'(read_en), 0);
         chk("t3_read_addr", int'(read_address), 0);
         tick;
      end
      hold_rd_low = 0;
      take_result(0);
      chk("t3_y", int'(last_y), 1);
      chk("t3_err", int'(last_err), 0);

      // Y status stuck at 0: abort after MAX_POLL cycles in POLL_Y
      stuck_y = 1; exp_err = 1;
      send_pair(1, 1);
      n = 0; k = 0;
      while (!res_valid && k < 200) begin
         if (read_address == 3'd2) n++;
         tick; k++;
      end
      chk("t4_poll_y_cycles", n, 16);
      chk("t4_res_err", int'(res_err), 1);
      chk("t4_res_y", int'(res_y), 0);
      take_result(0);
      stuck_y = 0; exp_err = 0;
      dq_a.delete(); dq_b.delete(); dq_y.delete();
      send_pair(1, 0);
      take_result(0);
      chk("t4_next_y", int'(last_y), 1);
      chk("t4_next_err", int'(last_err), 0);
      chk("t4_txn_count", int'(txn_count), 7);

      // Result held off for 10 cycles while another pair is offered
      send_pair(1, 0);
      k = 0;
      while (!res_valid && k < 50) begin tick; k++; end
      op_valid = 1'b1; op_a = 1'b1; op_b = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("t5_res_valid", int'(res_valid), 1);
         chk("t5_res_y", int'(res_y), 1);
         chk("t5_op_ready", int'(op_ready), 0);
         chk("t5_txn_hold", int'(txn_count), 7);
         tick;
      end
      op_valid = 1'b0;
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      chk("t5_txn_after", int'(txn_count), 8);

      // Asynchronous reset while in WR_B
      send_pair(1, 1);
      k = 0;
      while (write_address != 3'd5 && k < 20) begin tick; k++; end
      chk("t6_reach_wr_b", int'(write_address), 5);
      #1 RST_N = 1'b1;
      #1;
      chk("t6_op_ready", int'(op_ready), 1);
      chk("t6_write_en", int'(write_en), 0);
      chk("t6_read_en", int'(read_en), 0);
      chk("t6_res_valid", int'(res_valid), 0);
      chk("t6_txn_count", int'(txn_count), 0);
      chk("t6_write_address", int'(write_address), 0);
      chk("t6_read_address", int'(read_address), 0);
      @(negedge CLK);
      @(posedge CLK);
      #2 RST_N = 1'b0;

      // Randomized pairs, dut stalls and result back-pressure (crosses the count wrap)
      rand_mode = 1;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 2)) tick;
         send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         take_result(int'($urandom_range(0, 3)));
      end
      chk("rand_txn_wrap", int'(txn_count), 44);

      repeat (3) tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
